// File: rtl/data_source_pkg.sv
// data_source_pkg: shared types and helpers for the parallel ramp data source.
package data_source_pkg;

    // Width of the optional channel tag placed in the top bits of each lane.
    localparam int TAG_W = 8;

    // Top-level control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of beats needed to carry num_ch channels over num_lanes lanes.
    function automatic int beats_f(input int num_ch, input int num_lanes);
        return (num_ch + num_lanes - 1) / num_lanes;
    endfunction

endpackage

// File: rtl/data_source_tick_gen.sv
// data_source_tick_gen: sample-period counter producing a one-cycle tick
// every TICK_DIV enabled cycles. The tick fires while the counter is 0, so
// the first tick lands in the first enabled cycle after a clear.
module data_source_tick_gen #(
    parameter int TICK_DIV = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next counter value: clear wins, otherwise count 0..TICK_DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick decode from the registered counter.
    always_comb begin
        tick = enable && (cnt_q == '0);
    end

endmodule

// File: rtl/data_source_parallel_gen.sv
// data_source_parallel_gen: multi-channel ramp test-data source.
// Each sample tick produces one set of NUM_CH values (base + channel) that is
// serialised over NUM_LANES lanes per beat with valid/ready back-pressure.
// Optional build macro DATA_SOURCE_TAG_EN: the top TAG_W bits of every valid
// lane carry channel index + 1 (needs DATA_WIDTH >= 16).
module data_source_parallel_gen
    import data_source_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 10,
    parameter int NUM_LANES  = 2,
    parameter int START      = -512,
    parameter int END        = 512,
    parameter int STRIDE     = 1,
    parameter int TICK_DIV   = 40,
    parameter int REPEAT     = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            trigger,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]            out_lane_valid,
    output logic                            out_sof,
    output logic                            out_eof,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun
);

    localparam int BEATS  = beats_f(NUM_CH, NUM_LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [DATA_WIDTH-1:0]     START_V  = DATA_WIDTH'(START);
    localparam logic signed [DATA_WIDTH:0] END_W    = (DATA_WIDTH + 1)'(END);
    localparam logic signed [DATA_WIDTH:0] STRIDE_W = (DATA_WIDTH + 1)'(STRIDE);

    state_e                          state_q, state_d;
    logic                            trig_prev_q, trig_prev_d;
    logic [DATA_WIDTH-1:0]           base_q, base_d;
    logic                            final_q, final_d;
    logic                            overrun_q, overrun_d;
    logic                            valid_q, valid_d;
    logic [DATA_WIDTH-1:0]           ser_base_q, ser_base_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_LANES-1:0]            lane_valid_q, lane_valid_d;
    logic                            sof_q, sof_d;
    logic                            eof_q, eof_d;

    logic                            trig_rise_s;
    logic                            start_s;
    logic                            xfer_s;
    logic                            last_xfer_s;
    logic                            ser_free_s;
    logic                            tick_en_s;
    logic                            tick_s;
    logic                            load_s;
    logic                            drop_s;
    logic signed [DATA_WIDTH:0]      base_step_s;
    logic                            range_end_s;
    logic                            busy_s;
    logic                            done_s;

    // Handshake, trigger edge and tick qualification.
    always_comb begin
        trig_prev_d = trigger;
        trig_rise_s = trigger && !trig_prev_q;
        start_s     = trig_rise_s && (state_q != ST_RUN);
        xfer_s      = valid_q && out_ready;
        last_xfer_s = xfer_s && eof_q;
        ser_free_s  = !valid_q || last_xfer_s;
        tick_en_s   = (state_q == ST_RUN) && !final_q;
        load_s      = tick_s && ser_free_s;
        drop_s      = tick_s && !ser_free_s;
        base_step_s = $signed({base_q[DATA_WIDTH-1], base_q}) + STRIDE_W;
        range_end_s = (base_step_s > END_W);
    end

    data_source_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (tick_en_s),
        .clear  (start_s),
        .tick   (tick_s)
    );

    // Base advance on every tick (loaded or dropped), end-of-range handling, sticky overrun.
    always_comb begin
        base_d    = base_q;
        final_d   = final_q;
        overrun_d = overrun_q | drop_s;
        if (start_s) begin
            base_d  = START_V;
            final_d = 1'b0;
        end else if (tick_s) begin
            if (!range_end_s) begin
                base_d = base_step_s[DATA_WIDTH-1:0];
            end else if (REPEAT != 0) begin
                base_d = START_V;
            end else begin
                base_d  = base_q;
                final_d = 1'b1;
            end
        end else begin
            base_d = base_q;
        end
    end

    // Serialiser: load a new set on a tick when free, otherwise step beats on transfer.
    always_comb begin
        valid_d    = valid_q;
        ser_base_d = ser_base_q;
        beat_d     = beat_q;
        if (load_s) begin
            valid_d    = 1'b1;
            ser_base_d = base_q;
            beat_d     = '0;
        end else if (xfer_s) begin
            if (eof_q) begin
                valid_d = 1'b0;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Beat formatting from the next serialiser state; a stalled beat recomputes identically.
    always_comb begin : fmt_lanes
        int                    ch;
        logic [DATA_WIDTH-1:0] val;
        ch           = 0;
        val          = '0;
        data_d       = '0;
        lane_valid_d = '0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        if (valid_d) begin
            sof_d = (beat_d == '0);
            eof_d = (beat_d == BEAT_W'(BEATS - 1));
            for (int l = 0; l < NUM_LANES; l++) begin
                ch = int'(beat_d) * NUM_LANES + l;
                if (ch < NUM_CH) begin
                    val = ser_base_d + DATA_WIDTH'(ch);
`ifdef DATA_SOURCE_TAG_EN
                    val[DATA_WIDTH-1 -: TAG_W] = TAG_W'(ch + 1);
`endif
                    data_d[l*DATA_WIDTH +: DATA_WIDTH] = val;
                    lane_valid_d[l]                    = 1'b1;
                end else begin
                    data_d[l*DATA_WIDTH +: DATA_WIDTH] = '0;
                    lane_valid_d[l]                    = 1'b0;
                end
            end
        end else begin
            data_d = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: single pass ends once the last loaded set has drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) state_d = ST_RUN;
                else         state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (final_q && ser_free_s) state_d = ST_DONE;
                else                       state_d = ST_RUN;
            end
            ST_DONE: begin
                if (start_s) state_d = ST_RUN;
                else         state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_q)
            ST_RUN:  busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath registers; trigger history resets high so a held trigger does not start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_prev_q  <= 1'b1;
            base_q       <= START_V;
            final_q      <= 1'b0;
            overrun_q    <= 1'b0;
            valid_q      <= 1'b0;
            ser_base_q   <= '0;
            beat_q       <= '0;
            data_q       <= '0;
            lane_valid_q <= '0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
        end else begin
            trig_prev_q  <= trig_prev_d;
            base_q       <= base_d;
            final_q      <= final_d;
            overrun_q    <= overrun_d;
            valid_q      <= valid_d;
            ser_base_q   <= ser_base_d;
            beat_q       <= beat_d;
            data_q       <= data_d;
            lane_valid_q <= lane_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_data       = data_q;
    assign out_lane_valid = lane_valid_q;
    assign out_sof        = sof_q;
    assign out_eof        = eof_q;
    assign busy           = busy_s;
    assign done           = done_s;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_data_source_parallel_gen.sv
// tb_data_source_parallel_gen: four instances in different configurations,
// each checked against a set-level reference model (queue of expected beats).
module tb_data_source_parallel_gen;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       trig;
    logic [3:0]       rdy;
    logic [3:0]       vld;
    logic [3:0][63:0] dat;
    logic [3:0][1:0]  lvm;
    logic [3:0]       sofv;
    logic [3:0]       eofv;
    logic [3:0]       busyv;
    logic [3:0]       donev;
    logic [3:0]       ovr;

    int checks = 0;
    int errors = 0;

    // configuration of each instance, as seen by the model
    int cfg_nc [4] = '{10, 3, 4, 4};
    int cfg_td [4] = '{40, 8, 8, 2};
    int cfg_st [4] = '{-512, -512, 0, 0};
    int cfg_en [4] = '{512, 512, 2, 3};
    int cfg_sd [4] = '{1, 1, 1, 2};
    int cfg_rp [4] = '{1, 1, 0, 1};
    bit ov_model [4];

    always #5 clk = ~clk;

    data_source_parallel_gen u0 (
        .clk(clk), .rst_n(rst_n), .trigger(trig[0]), .out_ready(rdy[0]),
        .out_valid(vld[0]), .out_data(dat[0]), .out_lane_valid(lvm[0]),
        .out_sof(sofv[0]), .out_eof(eofv[0]), .busy(busyv[0]), .done(donev[0]),
        .overrun(ovr[0]));

    data_source_parallel_gen #(.NUM_CH(3), .TICK_DIV(8)) u1 (
        .clk(clk), .rst_n(rst_n), .trigger(trig[1]), .out_ready(rdy[1]),
        .out_valid(vld[1]), .out_data(dat[1]), .out_lane_valid(lvm[1]),
        .out_sof(sofv[1]), .out_eof(eofv[1]), .busy(busyv[1]), .done(donev[1]),
        .overrun(ovr[1]));

    data_source_parallel_gen #(.NUM_CH(4), .START(0), .END(2), .REPEAT(0), .TICK_DIV(8)) u2 (
        .clk(clk), .rst_n(rst_n), .trigger(trig[2]), .out_ready(rdy[2]),
        .out_valid(vld[2]), .out_data(dat[2]), .out_lane_valid(lvm[2]),
        .out_sof(sofv[2]), .out_eof(eofv[2]), .busy(busyv[2]), .done(donev[2]),
        .overrun(ovr[2]));

    data_source_parallel_gen #(.NUM_CH(4), .START(0), .END(3), .STRIDE(2), .TICK_DIV(2)) u3 (
        .clk(clk), .rst_n(rst_n), .trigger(trig[3]), .out_ready(rdy[3]),
        .out_valid(vld[3]), .out_data(dat[3]), .out_lane_valid(lvm[3]),
        .out_sof(sofv[3]), .out_eof(eofv[3]), .busy(busyv[3]), .done(donev[3]),
        .overrun(ovr[3]));

    // Expected 2-lane beat: channel c = base + c (mod 2^32), absent lanes are zero.
    function automatic logic [63:0] exp_data(input longint base, input int beat, input int nc);
        logic [63:0] d;
        logic [31:0] v;
        int          ch;
        d = 64'd0;
        for (int l = 0; l < 2; l++) begin
            ch = beat * 2 + l;
            if (ch < nc) begin
                v = 32'(base + longint'(ch));
`ifdef DATA_SOURCE_TAG_EN
                v[31:24] = 8'(ch + 1);
`endif
                d[l*32 +: 32] = v;
            end
        end
        return d;
    endfunction

    function automatic logic [1:0] exp_lv(input int beat, input int nc);
        logic [1:0] m;
        m = 2'b00;
        for (int l = 0; l < 2; l++) begin
            if (beat * 2 + l < nc) m[l] = 1'b1;
        end
        return m;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        trig  = 4'b1111;
        rdy   = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) ov_model[s] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Trigger low for a cycle then high; returns in the first RUN cycle (cycle 0).
    task automatic start_run(input int s);
        trig[s] = 1'b0;
        rdy[s]  = 1'b0;
        @(posedge clk);
        #1;
        trig[s] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Start instance s and check it against the set-level model for ncyc cycles.
    task automatic run_stream(input int s, input int ncyc, input int rpct, input int hold, input bit tnoise);
        longint b, nb;
        bit     fin, ev, acc, tk, dn;
        longint qb[$];
        int     qi[$];
        int     beats;
        beats = (cfg_nc[s] + 1) / 2;
        start_run(s);
        b   = longint'(cfg_st[s]);
        fin = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            ev = (qb.size() != 0);
            dn = fin && !ev;
            checks++;
            if (vld[s] !== ev) begin
                errors++; $display("FAIL valid s=%0d n=%0d got=%b exp=%b", s, n, vld[s], ev);
            end
            if (ev) begin
                checks++;
                if (dat[s] !== exp_data(qb[0], qi[0], cfg_nc[s])) begin
                    errors++; $display("FAIL data s=%0d n=%0d got=%h exp=%h", s, n, dat[s], exp_data(qb[0], qi[0], cfg_nc[s]));
                end
                checks++;
                if (lvm[s] !== exp_lv(qi[0], cfg_nc[s])) begin
                    errors++; $display("FAIL lane_valid s=%0d n=%0d got=%b exp=%b", s, n, lvm[s], exp_lv(qi[0], cfg_nc[s]));
                end
                checks++;
                if (sofv[s] !== (qi[0] == 0)) begin
                    errors++; $display("FAIL sof s=%0d n=%0d got=%b exp=%b", s, n, sofv[s], (qi[0] == 0));
                end
                checks++;
                if (eofv[s] !== (qi[0] == beats - 1)) begin
                    errors++; $display("FAIL eof s=%0d n=%0d got=%b exp=%b", s, n, eofv[s], (qi[0] == beats - 1));
                end
            end
            checks++;
            if (ovr[s] !== ov_model[s]) begin
                errors++; $display("FAIL overrun s=%0d n=%0d got=%b exp=%b", s, n, ovr[s], ov_model[s]);
            end
            checks++;
            if (donev[s] !== dn) begin
                errors++; $display("FAIL done s=%0d n=%0d got=%b exp=%b", s, n, donev[s], dn);
            end
            checks++;
            if (busyv[s] !== !dn) begin
                errors++; $display("FAIL busy s=%0d n=%0d got=%b exp=%b", s, n, busyv[s], !dn);
            end
            rdy[s] = (n < hold) ? 1'b0 : ($urandom_range(99) < rpct);
            if (tnoise && !fin) trig[s] = 1'($urandom_range(1));
            acc = ev && rdy[s];
            if (acc) begin
                void'(qb.pop_front());
                void'(qi.pop_front());
            end
            tk = !fin && ((n % cfg_td[s]) == 0);
            if (tk) begin
                if (qb.size() == 0) begin
                    for (int k = 0; k < beats; k++) begin
                        qb.push_back(b);
                        qi.push_back(k);
                    end
                end else begin
                    ov_model[s] = 1'b1;
                end
                nb = b + longint'(cfg_sd[s]);
                if (nb > longint'(cfg_en[s])) begin
                    if (cfg_rp[s] != 0) b = longint'(cfg_st[s]);
                    else                fin = 1'b1;
                end else begin
                    b = nb;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 4; s++) begin
            checks++;
            if ({vld[s], dat[s], lvm[s], sofv[s], eofv[s], busyv[s], donev[s], ovr[s]} !== 71'd0) begin
                errors++; $display("FAIL reset_outputs s=%0d got=%h exp=0", s,
                    {vld[s], dat[s], lvm[s], sofv[s], eofv[s], busyv[s], donev[s], ovr[s]});
            end
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busyv !== 4'b0000) begin
            errors++; $display("FAIL held_trigger_start got=%b exp=0000", busyv);
        end
    endtask

    task automatic test_default_ramp();
        logic [63:0] e;
        logic [31:0] l0;
        do_reset();
        start_run(0);
        rdy[0] = 1'b1;
        for (int n = 0; n < 46; n++) begin
            if (n == 1) begin
                e = exp_data(-512, 0, 10);
                checks++;
                if (dat[0] !== e || sofv[0] !== 1'b1) begin
                    errors++; $display("FAIL beat0 got=%h sof=%b exp=%h sof=1", dat[0], sofv[0], e);
                end
`ifndef DATA_SOURCE_TAG_EN
                checks++;
                if (dat[0] !== 64'hFFFFFE01_FFFFFE00) begin
                    errors++; $display("FAIL beat0_literal got=%h exp=fffffe01fffffe00", dat[0]);
                end
`else
                checks++;
                if (dat[0][31:24] !== 8'h01) begin
                    errors++; $display("FAIL tag_lane0 got=%h exp=01", dat[0][31:24]);
                end
`endif
            end
            if (n == 5) begin
                e = exp_data(-512, 4, 10);
                checks++;
                if (dat[0] !== e || eofv[0] !== 1'b1) begin
                    errors++; $display("FAIL beat4 got=%h eof=%b exp=%h eof=1", dat[0], eofv[0], e);
                end
`ifndef DATA_SOURCE_TAG_EN
                checks++;
                if (dat[0] !== 64'hFFFFFE09_FFFFFE08) begin
                    errors++; $display("FAIL beat4_literal got=%h exp=fffffe09fffffe08", dat[0]);
                end
`endif
            end
            if (n == 6) begin
                checks++;
                if (vld[0] !== 1'b0) begin
                    errors++; $display("FAIL idle_gap got=%b exp=0", vld[0]);
                end
            end
            if (n == 41) begin
                e  = exp_data(-511, 0, 10);
                l0 = e[31:0];
                checks++;
                if (sofv[0] !== 1'b1 || dat[0][31:0] !== l0) begin
                    errors++; $display("FAIL second_set sof=%b lane0=%h exp sof=1 lane0=%h", sofv[0], dat[0][31:0], l0);
                end
            end
            @(posedge clk);
            #1;
        end
        do_reset();
        run_stream(0, 300, 60, 0, 1'b1);
        do_reset();
        run_stream(0, 300, 10, 0, 1'b1);
    endtask

    task automatic test_partial_lanes();
        do_reset();
        start_run(1);
        rdy[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (n == 1) begin
                checks++;
                if (lvm[1] !== 2'b11 || sofv[1] !== 1'b1) begin
                    errors++; $display("FAIL p_beat0 lv=%b sof=%b exp lv=11 sof=1", lvm[1], sofv[1]);
                end
            end
            if (n == 2) begin
                checks++;
                if (lvm[1] !== 2'b01 || dat[1][63:32] !== 32'd0 || eofv[1] !== 1'b1) begin
                    errors++; $display("FAIL p_beat1 lv=%b lane1=%h eof=%b exp lv=01 lane1=0 eof=1", lvm[1], dat[1][63:32], eofv[1]);
                end
            end
            if (n == 3) begin
                checks++;
                if (vld[1] !== 1'b0) begin
                    errors++; $display("FAIL p_no_beat2 got=%b exp=0", vld[1]);
                end
            end
            @(posedge clk);
            #1;
        end
        do_reset();
        run_stream(1, 200, 50, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [63:0] b0, expd, cap;
        int          rel, nt, found;
        longint      eb;
        do_reset();
        start_run(0);
        rdy[0] = 1'b0;
        b0 = exp_data(-512, 0, 10);
        for (int n = 0; n < 100; n++) begin
            if (n >= 1) begin
                checks++;
                if (vld[0] !== 1'b1 || dat[0] !== b0 || sofv[0] !== 1'b1) begin
                    errors++; $display("FAIL stall_hold n=%0d v=%b d=%h exp v=1 d=%h", n, vld[0], dat[0], b0);
                end
            end
            checks++;
            if (ovr[0] !== (n >= 41)) begin
                errors++; $display("FAIL stall_overrun n=%0d got=%b exp=%b", n, ovr[0], (n >= 41));
            end
            @(posedge clk);
            #1;
        end
        rel    = 100;
        rdy[0] = 1'b1;
        // held set drains in 5 beats; next tick on the 40-cycle grid afterwards
        nt    = ((rel + 5 + 39) / 40) * 40;
        eb    = -512 + longint'(nt / 40);
        found = -1;
        cap   = 64'd0;
        for (int n = rel; n < rel + 100 && found < 0; n++) begin
            if (n > rel && vld[0] === 1'b1 && sofv[0] === 1'b1) begin
                found = n;
                cap   = dat[0];
            end
            @(posedge clk);
            #1;
        end
        expd = exp_data(eb, 0, 10);
        checks++;
        if (found != nt + 1) begin
            errors++; $display("FAIL resume_cycle got=%0d exp=%0d", found, nt + 1);
        end
        checks++;
        if (cap !== expd) begin
            errors++; $display("FAIL resume_base got=%h exp=%h", cap, expd);
        end
    endtask

    task automatic test_single_pass();
        do_reset();
        run_stream(2, 60, 100, 0, 1'b1);
        run_stream(2, 60, 50, 0, 1'b0);
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        run_stream(3, 60, 100, 0, 1'b0);
        checks++;
        if (ovr[3] !== 1'b0) begin
            errors++; $display("FAIL b2b_overrun got=%b exp=0", ovr[3]);
        end
        do_reset();
        run_stream(3, 100, 70, 0, 1'b1);
    endtask

    task automatic test_reset_mid_set();
        do_reset();
        start_run(0);
        rdy[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (vld[0] !== 1'b1) begin
            errors++; $display("FAIL mid_set_valid got=%b exp=1", vld[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if ({vld[s], dat[s], lvm[s], sofv[s], eofv[s], busyv[s], donev[s], ovr[s]} !== 71'd0) begin
                errors++; $display("FAIL async_reset s=%0d got=%h exp=0", s,
                    {vld[s], dat[s], lvm[s], sofv[s], eofv[s], busyv[s], donev[s], ovr[s]});
            end
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) ov_model[s] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            checks++;
            if (busyv[0] !== 1'b0 || vld[0] !== 1'b0) begin
                errors++; $display("FAIL no_start_held n=%0d busy=%b valid=%b exp 0 0", n, busyv[0], vld[0]);
            end
            @(posedge clk);
            #1;
        end
        run_stream(0, 60, 100, 0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        trig  = 4'b1111;
        rdy   = 4'b0000;
        test_reset();
        test_default_ramp();
        test_partial_lanes();
        test_backpressure();
        test_single_pass();
        test_back_to_back_wrap();
        test_reset_mid_set();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
